// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter through a newd/donetx handshake.
// Define UART_TXFIFO_OVF_EN to enable the sticky overflow flag.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          newd,
    output logic [7:0]    datatx,
    input  logic          donetx,
    input  logic          ovf_clr,
    output logic          overflow
);
    typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;
    state_t state, state_nxt;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [1:0] sync;
    logic done_s, done_q, rise, pop, push;
    logic [AW:0] count_nxt;

    assign done_s = sync[1];
    assign rise = done_s & ~done_q;
    assign pop = (state == IDLE) & ~empty;
    assign push = wr_en & ~full;
    assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wr_data;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            datatx <= 8'h00;
            sync   <= 2'b00;
            done_q <= 1'b0;
            state  <= IDLE;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            datatx <= pop ? mem[rd_ptr] : datatx;
            count  <= count_nxt;
            full   <= count_nxt == (AW+1)'(DEPTH);
            empty  <= count_nxt == '0;
            sync   <= {sync[0], donetx};
            done_q <= done_s;
            state  <= state_nxt;
        end

    // DRAIN waits for the synchronized done to drop so one pulse never completes two frames
    always_comb
        state_nxt = state == IDLE ? (empty ? IDLE : SEND) :
                    state == SEND ? (rise ? DRAIN : SEND) :
                    (done_s ? DRAIN : IDLE);

    always_comb
        newd = state == SEND;

`ifdef UART_TXFIFO_OVF_EN
    // a pop on the same edge frees a slot, so that drop does not count as overflow
    always_ff @(posedge clk or posedge rst)
        if (rst) overflow <= 1'b0;
        else if (wr_en & full & ~pop) overflow <= 1'b1;
        else if (ovf_clr) overflow <= 1'b0;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign overflow = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized checks of uart_tx_fifo against a queue-based model.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;
`ifdef UART_TXFIFO_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b0, wr_en = 1'b0, donetx = 1'b0, ovf_clr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic full, empty, newd, overflow;
    logic [4:0] count;
    logic [7:0] datatx;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .newd(newd),
        .datatx(datatx), .donetx(donetx), .ovf_clr(ovf_clr), .overflow(overflow)
    );

    // reference: byte queue plus handshake timing taken from the edge counts of the interface
    logic [7:0] q[$];
    logic [7:0] m_dat = 8'h00;
    bit m_send = 0, m_ovf = 0, prev_done = 0, m_pop;
    int cyc = 0, issue_from = 0, off_at = -1, m_sz;

    always @(posedge clk or posedge rst)
        if (rst) begin
            q.delete();
            m_send = 0; m_dat = 8'h00; m_ovf = 0;
            issue_from = 0; off_at = -1; prev_done = 0;
        end else begin
            cyc++;
            if (donetx && !prev_done) begin off_at = cyc + 2; issue_from = 1 << 30; end
            if (!donetx && prev_done) issue_from = cyc + 3;
            prev_done = donetx;
            m_sz = q.size();
            m_pop = !m_send && cyc >= issue_from && m_sz > 0;
            if (m_send && cyc == off_at) m_send = 0;
            if (OVF) begin
                if (wr_en && m_sz == DEPTH && !m_pop) m_ovf = 1;
                else if (ovf_clr) m_ovf = 0;
            end
            if (m_pop) begin m_dat = q.pop_front(); m_send = 1; end
            if (wr_en && m_sz < DEPTH) q.push_back(wr_data);
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // transmitter emulator: random latency, then a 2..4 cycle donetx pulse per frame
    bit auto_tx = 0;
    int tx_phase = 0, tx_wait = 0, tx_len = 0;
    task automatic tx_tick();
        if (tx_len > 0) begin
            donetx = 1'b1;
            tx_len--;
        end else begin
            donetx = 1'b0;
            if (!m_send) tx_phase = 0;
            else if (tx_phase == 0) begin tx_phase = 1; tx_wait = $urandom_range(0, 4); end
            else if (tx_phase == 1) begin
                if (tx_wait == 0) begin
                    tx_phase = 2;
                    tx_len = $urandom_range(1, 3);
                    donetx = 1'b1;
                end else tx_wait--;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (!rst) begin
            chk("count", 32'(count), 32'(q.size()));
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("newd", 32'(newd), 32'(m_send));
            chk("datatx", 32'(datatx), 32'(m_dat));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("count_max", 32'(count <= 5'(DEPTH)), 32'd1);
        end
        if (auto_tx) tx_tick();
    endtask

    task automatic drain();
        auto_tx = 1;
        for (int i = 0; i < 4000 && (q.size() > 0 || m_send); i++) step();
        repeat (10) step();
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_newd", 32'(newd), 32'd0);
        auto_tx = 0; tx_phase = 0; tx_len = 0; donetx = 1'b0;
    endtask

    bit hit;

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_newd", 32'(newd), 32'd0);
        chk("rst_datatx", 32'(datatx), 32'h00);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // single byte
        wr_en = 1'b1; wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        chk("sb_count1", 32'(count), 32'd1);
        chk("sb_empty0", 32'(empty), 32'd0);
        chk("sb_newd0", 32'(newd), 32'd0);
        step();
        chk("sb_newd1", 32'(newd), 32'd1);
        chk("sb_data", 32'(datatx), 32'hA5);
        chk("sb_count0", 32'(count), 32'd0);
        repeat (2) step();
        donetx = 1'b1;
        step(); step();
        chk("sb_newd_hold", 32'(newd), 32'd1);
        step();
        chk("sb_newd_fall", 32'(newd), 32'd0);
        step();
        donetx = 1'b0;
        repeat (6) step();
        chk("sb_empty_end", 32'(empty), 32'd1);

        // burst to full with the transmitter stalled
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
        end
        chk("burst_full0", 32'(full), 32'd0);
        chk("burst_cnt15", 32'(count), 32'd15);
        chk("burst_head", 32'(datatx), 32'h01);
        wr_data = 8'h11;
        step();
        chk("burst_full1", 32'(full), 32'd1);
        chk("burst_cnt16", 32'(count), 32'd16);

        // overflow
        wr_data = 8'hEE;
        step();
        chk("ovf_cnt", 32'(count), 32'd16);
        chk("ovf_set", 32'(overflow), 32'(OVF));
        ovf_clr = 1'b1;
        step();
        chk("ovf_setwins", 32'(overflow), 32'(OVF));
        wr_en = 1'b0;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);
        drain();
        chk("burst_last", 32'(datatx), 32'h11);

        // write on the pop edge
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'h21 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        chk("sim_pre", 32'(count), 32'd3);
        donetx = 1'b1;
        step(); step();
        donetx = 1'b0;
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            if (!m_send && cyc + 1 >= issue_from && q.size() == 3) begin hit = 1; break; end
            step();
        end
        chk("sim_reach", 32'(hit), 32'd1);
        wr_en = 1'b1; wr_data = 8'h55;
        step();
        wr_en = 1'b0;
        chk("sim_count", 32'(count), 32'd3);
        chk("sim_newd", 32'(newd), 32'd1);
        chk("sim_data", 32'(datatx), 32'h22);
        drain();
        chk("sim_last", 32'(datatx), 32'h55);

        // asynchronous reset mid-SEND
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'h31 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        chk("mr_cnt5", 32'(count), 32'd5);
        chk("mr_newd", 32'(newd), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("mr_newd0", 32'(newd), 32'd0);
        chk("mr_data0", 32'(datatx), 32'h00);
        chk("mr_empty", 32'(empty), 32'd1);
        chk("mr_count", 32'(count), 32'd0);
        chk("mr_full", 32'(full), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) step();
        chk("mr_quiet", 32'(newd), 32'd0);

        // randomized traffic with pointer wrap and occasional overflow
        auto_tx = 1;
        for (int i = 0; i < 900; i++) begin
            wr_en = ($urandom_range(0, 2) == 0);
            wr_data = 8'($urandom);
            ovf_clr = ($urandom_range(0, 7) == 0);
            step();
        end
        wr_en = 1'b0; ovf_clr = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
